uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM encoding, default frame parameters, output FIFO depth.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Default number of sample ticks per bit and data bits per frame.
    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DATA_BITS_DEF  = 8;

    // Depth of the optional receive FIFO (must be a power of two).
    localparam int UART_RX_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO: DEPTH entries (power of two), show-ahead head on rd_data_o.
// Latency: a write is visible on rd_data_o / empty_o the cycle after wr_en_i.
// Backpressure: writes are ignored when full unless a read happens in the same cycle.
//
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i  : push request and data
//   rd_en_i             : pop the head entry (ignored when empty)
//   rd_data_o           : head entry
//   full_o, empty_o     : occupancy flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS_DEF,
    parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = AW + 1;

    // Pointers carry one wrap bit so full and empty can be told apart.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // A write into a full FIFO is allowed when the head leaves in the same
    // cycle; the slot being written is the one being freed.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_wr) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
            end
        end
    end

endmodule : uart_rx_fifo

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop detection with one-entry (or 4-entry FIFO) output storage.
// Latency: byte appears on valid/byte_received the cycle after the mid-stop-bit sample.
// Backpressure: ready only drains storage; reception continues, a byte arriving to full storage is dropped with overrun.
//
// Build option: define UART_RX_FIFO_EN to replace the holding register with a 4-entry FIFO.
//
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   sample_tick      : one-cycle strobe at OVERSAMPLE x baud
//   rx               : asynchronous serial input, idle high
//   byte_received    : stored byte (head of storage), stable while valid
//   valid, ready     : output handshake, transfer on valid && ready
//   framing_error    : one-cycle pulse when the stop bit is sampled low
//   overrun          : one-cycle pulse when a completed byte is dropped
// OVERSAMPLE must be even and at least 8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] byte_received,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 byte_done;
    logic                 frame_err;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        frame_err  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sample_tick && !rx_sync_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end

            START: begin
                if (sample_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        // Mid start bit: a line that went high again was a glitch.
                        tick_cnt_d = '0;
                        if (!rx_sync_q) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end

            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // LSB arrives first, so shifting in at the top leaves
                        // the word correctly ordered after the last bit.
                        shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end

            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_sync_q) begin
                            byte_done = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = WAIT_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end

            WAIT_IDLE: begin
                // Hold off while the line is in break / stuck low.
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Output storage
    // ------------------------------------------------------------------
    logic xfer;
    logic overrun_d;

    assign xfer = valid && ready;

`ifdef UART_RX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (UART_RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (byte_done),
        .wr_data_i (shift_q),
        .rd_en_i   (xfer),
        .rd_data_o (byte_received),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign valid     = !fifo_empty;
    // A pop in the same cycle frees a slot, so that byte is not lost.
    assign overrun_d = byte_done && fifo_full && !xfer;
`else
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        overrun_d  = 1'b0;
        if (byte_done) begin
            if (!hold_vld_q || xfer) begin
                hold_d     = shift_q;
                hold_vld_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (xfer) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign byte_received = hold_q;
    assign valid         = hold_vld_q;
`endif

    // ------------------------------------------------------------------
    // Error pulses
    // ------------------------------------------------------------------
    logic framing_error_q, overrun_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            framing_error_q <= frame_err;
            overrun_q       <= overrun_d;
        end
    end

    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule : uart_rx
